// File: rtl/serial_link_pkg.sv
// Shared types and widths for the half-duplex serial link controller and datapath.
package serial_link_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/serial_link_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set candidate at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos;

  // Scan ptr, ptr+1, ... modulo N_REQ and keep the first hit
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + SUM_W'(k);
      if (pos >= SUM_W'(N_REQ)) begin
        pos = pos - SUM_W'(N_REQ);
      end
      if (!grant_valid && cand[pos[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/serial_link_ctrl.sv
// Transmit arbitration/sequencing and receive holding register for the serial link.
module serial_link_ctrl
  import serial_link_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned GUARD_CYCLES  = 32,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [BYTE_W*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     rx_active,
  input  logic                     rx_valid,
  input  logic [BYTE_W-1:0]        rx_data,
  output logic [BYTE_W-1:0]        rx_byte,
  output logic                     rx_ready,
  input  logic                     rx_ack,
  input  logic                     clr_flags,
  output logic                     rx_overflow,
  output logic                     tx_err,
  output logic                     is_sending,
  output logic                     is_receiving
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned GRD_W = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]   cur_idx, cur_idx_next;
  logic [BYTE_W-1:0]  tx_data_next;
  logic               tx_start_next;
  logic [N_REQ-1:0]   ack_next;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_next;
  logic               err_set;
  logic [GRD_W-1:0]   guard_cnt;
  logic               eligible;
  logic [N_REQ-1:0]   cand;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [BYTE_W-1:0]  grant_data;

  // The requester being acked this cycle is masked so its dropping req is not re-granted
  assign cand     = req & ~ack;
  assign eligible = (guard_cnt == '0) && !rx_active;

  assign is_sending   = (state != IDLE);
  assign is_receiving = rx_active;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .cand        (cand),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Select the byte of the granted requester
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_data = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Next-state and next registered-output logic of the transmit sequencer
  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    cur_idx_next  = cur_idx;
    tx_data_next  = tx_data;
    tx_start_next = 1'b0;
    ack_next      = '0;
    tmo_cnt_next  = tmo_cnt;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        if (eligible && grant_valid) begin
          state_next    = START;
          cur_idx_next  = grant_idx;
          tx_data_next  = grant_data;
          tx_start_next = 1'b1;
          rr_ptr_next   = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
      end
      START: begin
        state_next   = WAIT_BUSY;
        tmo_cnt_next = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_cnt == TMO_W'(START_TIMEOUT - 1)) begin
          state_next        = IDLE;
          err_set           = 1'b1;
          ack_next[cur_idx] = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next        = IDLE;
          ack_next[cur_idx] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state and registered transmit outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_idx  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ack      <= '0;
      tmo_cnt  <= '0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      cur_idx  <= cur_idx_next;
      tx_data  <= tx_data_next;
      tx_start <= tx_start_next;
      ack      <= ack_next;
      tmo_cnt  <= tmo_cnt_next;
      if (err_set) begin
        tx_err <= 1'b1;
      end else if (clr_flags) begin
        tx_err <= 1'b0;
      end
    end
  end

  // Turnaround guard: reload while receiving, then count down to zero
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      guard_cnt <= GRD_W'(GUARD_CYCLES);
    end else if (rx_active) begin
      guard_cnt <= GRD_W'(GUARD_CYCLES);
    end else if (guard_cnt != '0) begin
      guard_cnt <= guard_cnt - GRD_W'(1);
    end
  end

  // One-deep receive holding register with sticky overflow
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_byte     <= '0;
      rx_ready    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_valid) begin
        if (!rx_ready || rx_ack) begin
          rx_byte  <= rx_data;
          rx_ready <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_ready <= 1'b0;
      end
      if (rx_valid && rx_ready && !rx_ack) begin
        rx_overflow <= 1'b1;
      end else if (clr_flags) begin
        rx_overflow <= 1'b0;
      end
    end
  end

endmodule
